// File: rtl/bsg_gateway_mem_latency_pipe_pkg.sv
// Gateway-side timing constants shared by the memory delay line and the gateway I/O path.
// Includes the default transit latency, the pipe depth and the entry timer helper.
package bsg_gateway_mem_latency_pipe_pkg;

  localparam int gw_mem_latency_default_gp = 16;
  localparam int gw_mem_els_default_gp     = 8;
  localparam int gw_io_in_delay_gp         = 2;
  localparam int gw_io_out_delay_gp        = 2;

  localparam int timer_width_gp = 8;

  // Value an entry timer is loaded with so that it reaches zero exactly latency cycles after accept.
  function automatic logic [timer_width_gp-1:0] gw_timer_load(input int latency);
    return timer_width_gp'(latency - 1);
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file storage.
// Writes are synchronous and reads are asynchronous.
module bsg_mem_1r1w #(
  parameter int width_p       = 8,
  parameter int els_p         = 2,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bsg_gateway_mem_latency_pipe.sv
// In-order ready/valid delay line that enforces a minimum transit latency per message,
// modelling link/controller delay ahead of the DRAM model.
module bsg_gateway_mem_latency_pipe
  import bsg_gateway_mem_latency_pipe_pkg::*;
#(
  parameter int width_p   = 640,
  parameter int latency_p = gw_mem_latency_default_gp,
  parameter int els_p     = gw_mem_els_default_gp
) (
  input  logic                       blackparrot_clk,
  input  logic                       blackparrot_reset,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_and_o,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       ready_and_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [cnt_w_lp-1:0]       els_lp  = cnt_w_lp'(els_p);
  localparam logic [timer_width_gp-1:0] load_lp = gw_timer_load(latency_p);

  if (latency_p < 1 || latency_p > 255) begin : g_bad_latency
    $error("latency_p out of range 1..255");
  end
  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $error("els_p must be a power of 2 and at least 2");
  end

  logic [ptr_w_lp-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]       count_q, count_d;
  logic [timer_width_gp-1:0] timer_q [els_p];
  logic [timer_width_gp-1:0] timer_d [els_p];
  logic                      enq, deq;

  // Reset gates ready combinationally so nothing is accepted while it is held.
  assign ready_and_o = blackparrot_reset & (count_q != els_lp);
  assign v_o         = (count_q != '0) & (timer_q[rd_ptr_q] == '0);
  assign count_o     = count_q;
  assign enq         = v_i & ready_and_o;
  assign deq         = v_o & ready_and_i;

  always_comb begin
    rd_ptr_d = deq ? rd_ptr_q + ptr_w_lp'(1) : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + ptr_w_lp'(1) : wr_ptr_q;
    count_d  = count_q;
    if (enq && !deq)      count_d = count_q + cnt_w_lp'(1);
    else if (!enq && deq) count_d = count_q - cnt_w_lp'(1);
  end

  // Timers free-run toward zero independent of backpressure; only the enqueue slot reloads.
  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - timer_width_gp'(1) : '0;
      if (enq && (wr_ptr_q == ptr_w_lp'(i))) timer_d[i] = load_lp;
    end
  end

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < els_p; i++) timer_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < els_p; i++) timer_q[i] <= timer_d[i];
    end
  end

  bsg_mem_1r1w #(
    .width_p(width_p),
    .els_p  (els_p)
  ) mem (
    .w_clk_i (blackparrot_clk),
    .w_v_i   (enq),
    .w_addr_i(wr_ptr_q),
    .w_data_i(data_i),
    .r_addr_i(rd_ptr_q),
    .r_data_o(data_o)
  );

  a_no_retract: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
    (v_i && !ready_and_o) |=> v_i)
    else $error("v_i retracted while ready_and_o low");

  a_count_bound: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
    count_q <= els_lp)
    else $error("occupancy above depth");

endmodule

// File: tb/tb_bsg_gateway_mem_latency_pipe.sv
// Randomized and directed bench for the gateway memory latency pipe against a
// queue-based model: a message is visible once its accept cycle plus latency has passed.
module tb_bsg_gateway_mem_latency_pipe;

  localparam int W   = 640;
  localparam int LAT = 4;
  localparam int ELS = 4;

  logic         blackparrot_clk;
  logic         blackparrot_reset;
  logic [W-1:0] data_i;
  logic         v_i;
  logic         ready_and_o;
  logic [W-1:0] data_o;
  logic         v_o;
  logic         ready_and_i;
  logic [2:0]   count_o;

  bsg_gateway_mem_latency_pipe #(
    .width_p  (W),
    .latency_p(LAT),
    .els_p    (ELS)
  ) dut (
    .blackparrot_clk  (blackparrot_clk),
    .blackparrot_reset(blackparrot_reset),
    .data_i           (data_i),
    .v_i              (v_i),
    .ready_and_o      (ready_and_o),
    .data_o           (data_o),
    .v_o              (v_o),
    .ready_and_i      (ready_and_i),
    .count_o          (count_o)
  );

  initial blackparrot_clk = 1'b0;
  always #5 blackparrot_clk = ~blackparrot_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic last_enq = 1'b0;

  logic [W-1:0] mq_data [$];
  int           mq_acc  [$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock: compare outputs with the model at the falling edge, advance the model, step to posedge+1.
  task automatic step();
    int   exp_cnt;
    logic exp_rdy, exp_v, enq, deq;
    @(negedge blackparrot_clk);
    exp_cnt = mq_data.size();
    exp_rdy = exp_cnt < ELS;
    exp_v   = (exp_cnt > 0) && (cyc >= mq_acc[0] + LAT);
    chk("ready_and_o", W'(ready_and_o), W'(exp_rdy));
    chk("v_o", W'(v_o), W'(exp_v));
    chk("count_o", W'(count_o), W'(exp_cnt));
    if (exp_v) chk("data_o", data_o, mq_data[0]);
    enq = v_i && exp_rdy;
    deq = exp_v && ready_and_i;
    if (deq) begin
      void'(mq_data.pop_front());
      void'(mq_acc.pop_front());
      n_out++;
    end
    if (enq) begin
      mq_data.push_back(data_i);
      mq_acc.push_back(cyc);
      n_acc++;
    end
    last_enq = enq;
    @(posedge blackparrot_clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [W-1:0] d);
    v_i    = 1'b1;
    data_i = d;
    step();
    v_i = 1'b0;
  endtask

  initial begin
    int budget;
    int out0;
    blackparrot_reset = 1'b0;
    v_i         = 1'b0;
    ready_and_i = 1'b1;
    data_i      = '0;
    #12;
    chk("rst_v_o", W'(v_o), W'(1'b0));
    chk("rst_count", W'(count_o), W'(0));
    chk("rst_ready", W'(ready_and_o), W'(1'b0));
    #1 blackparrot_reset = 1'b1;
    @(posedge blackparrot_clk);
    #1;
    idle(3);

    // Single message
    send(W'(8'hA5));
    idle(6);

    // Fill with consumer stalled, then drain starting on the first valid cycle
    ready_and_i = 1'b0;
    for (int i = 0; i < ELS; i++) send(rand_data());
    ready_and_i = 1'b1;
    idle(6);

    // Head held under backpressure; second already expired behind it
    ready_and_i = 1'b0;
    send(rand_data());
    send(rand_data());
    idle(8);
    ready_and_i = 1'b1;
    idle(4);

    // Full with a pending offer: dequeue frees a slot only on the following cycle
    ready_and_i = 1'b0;
    for (int i = 0; i < ELS; i++) send(rand_data());
    v_i    = 1'b1;
    data_i = rand_data();
    idle(4);
    ready_and_i = 1'b1;
    budget = 0;
    do begin
      step();
      budget++;
    end while (!last_enq && budget < 20);
    chk("full_accept_timeout", W'(budget < 20), W'(1'b1));
    v_i = 1'b0;
    idle(10);

    // Asynchronous reset with two messages in flight
    send(rand_data());
    send(rand_data());
    #2 blackparrot_reset = 1'b0;
    #1;
    chk("midrst_v_o", W'(v_o), W'(1'b0));
    chk("midrst_count", W'(count_o), W'(0));
    chk("midrst_ready", W'(ready_and_o), W'(1'b0));
    mq_data.delete();
    mq_acc.delete();
    @(posedge blackparrot_clk);
    cyc++;
    #2 blackparrot_reset = 1'b1;
    idle(6);
    send(W'(8'h3C));
    idle(6);

    // Randomized traffic with gaps and backpressure
    out0   = n_out;
    n_acc  = 0;
    budget = 0;
    while ((n_acc < 20 || mq_data.size() > 0) && budget < 3000) begin
      if (!(v_i && !last_enq)) begin
        if (n_acc < 20 && $urandom_range(0, 2) != 0) begin
          v_i    = 1'b1;
          data_i = rand_data();
        end else begin
          v_i = 1'b0;
        end
      end
      ready_and_i = ($urandom_range(0, 3) != 0);
      step();
      budget++;
    end
    v_i = 1'b0;
    chk("rand_drained", W'(n_out - out0), W'(20));
    ready_and_i = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
